// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// pc_fetch_ctrl : PC sequencing controller (boot hold-off, imem wait, stall,
//                 branch redirect with optional delay slot, pending branch).
// Optional feature macro: PC_FETCH_CTRL_STATS_EN (adds br_count/stall_count).
// Revision: 1.0
// ============================================================================
module pc_fetch_ctrl #(
   parameter int unsigned BOOT_CYCLES = 2,
   parameter bit          DELAY_SLOT  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        imem_ready,
   input  logic        stall_req,
   input  logic        br_valid,
   input  logic        br_taken,
   input  logic        uncond_br,
   output logic        pc_we,
   output logic        pc_sel,
   output logic        br_sel,
   output logic        ifid_we,
   output logic        ifid_flush,
   output logic        fetch_valid,
`ifdef PC_FETCH_CTRL_STATS_EN
   output logic [2:0]  state_o,
   output logic [31:0] br_count,
   output logic [31:0] stall_count
`else
   output logic [2:0]  state_o
`endif
);

   typedef enum logic [2:0] {
      BOOT     = 3'd0,
      RUN      = 3'd1,
      MEMWAIT  = 3'd2,
      STALL    = 3'd3,
      REDIRECT = 3'd4
   } state_t;

   // BOOT_CYCLES of 0 and 1 both leave BOOT on the first edge after release
   localparam logic [3:0] BOOT_LAST = (BOOT_CYCLES > 1) ? 4'(BOOT_CYCLES - 1) : 4'd0;

   state_t     state, state_nxt;
   logic [3:0] boot_cnt, boot_cnt_nxt;
   logic       pend_valid, pend_valid_nxt;
   logic       pend_uncond, pend_uncond_nxt;
   logic       taken;

   assign taken   = br_valid & br_taken;
   assign state_o = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= BOOT;
         boot_cnt    <= 4'd0;
         pend_valid  <= 1'b0;
         pend_uncond <= 1'b0;
      end else begin
         state       <= state_nxt;
         boot_cnt    <= boot_cnt_nxt;
         pend_valid  <= pend_valid_nxt;
         pend_uncond <= pend_uncond_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      boot_cnt_nxt    = boot_cnt;
      pend_valid_nxt  = pend_valid;
      pend_uncond_nxt = pend_uncond;
      pc_we           = 1'b0;
      pc_sel          = 1'b0;
      br_sel          = 1'b0;
      ifid_we         = 1'b0;
      ifid_flush      = 1'b0;
      fetch_valid     = 1'b0;
      case (state)
         BOOT: begin
            ifid_flush   = 1'b1;
            boot_cnt_nxt = boot_cnt + 4'd1;
            if (boot_cnt == BOOT_LAST) state_nxt = RUN;
         end
         RUN: begin
            if (taken) begin
               pend_valid_nxt  = 1'b1;
               pend_uncond_nxt = uncond_br;
            end
            if (!imem_ready) begin
               ifid_flush = 1'b1;
               state_nxt  = MEMWAIT;
            end else if (stall_req) begin
               state_nxt = STALL;
            end else begin
               pc_we       = 1'b1;
               ifid_we     = 1'b1;
               fetch_valid = 1'b1;
               state_nxt   = taken ? REDIRECT : RUN;
            end
         end
         MEMWAIT: begin
            ifid_flush = 1'b1;
            if (imem_ready) state_nxt = pend_valid ? REDIRECT : RUN;
         end
         STALL: begin
            // youngest taken branch wins the single pending slot
            if (taken) begin
               pend_valid_nxt  = 1'b1;
               pend_uncond_nxt = uncond_br;
            end
            if (!stall_req) state_nxt = (pend_valid || taken) ? REDIRECT : RUN;
         end
         REDIRECT: begin
            // redirect is deferred (pending kept) behind memory wait or stall
            if (!imem_ready) begin
               ifid_flush = 1'b1;
               state_nxt  = MEMWAIT;
            end else if (stall_req) begin
               state_nxt = STALL;
            end else begin
               pc_we          = 1'b1;
               pc_sel         = 1'b1;
               br_sel         = pend_uncond;
               ifid_we        = 1'b1;
               ifid_flush     = ~DELAY_SLOT;
               fetch_valid    = DELAY_SLOT;
               pend_valid_nxt = 1'b0;
               state_nxt      = RUN;
            end
         end
         default: begin
            ifid_flush = 1'b1;
            state_nxt  = BOOT;
         end
      endcase
   end

`ifdef PC_FETCH_CTRL_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         br_count    <= 32'd0;
         stall_count <= 32'd0;
      end else begin
         if ((state == REDIRECT) && pc_we && (br_count != 32'hFFFF_FFFF))
            br_count <= br_count + 32'd1;
         if (((state == STALL) || (state == MEMWAIT)) && (stall_count != 32'hFFFF_FFFF))
            stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire
